// File: rtl/lm_pkg.sv
`default_nettype none
// ============================================================
// Package : lm_pkg
// Brief   : shared types and defaults for level_monitor
// Revision: 1.0
// ============================================================
package lm_pkg;

  localparam int DEBOUNCE_DEF = 3;
  localparam int EVW_DEF      = 8;

  typedef enum logic [1:0] {
    LOW     = 2'd0,
    PEND_HI = 2'd1,
    HIGH    = 2'd2,
    PEND_LO = 2'd3
  } lm_state_e;

endpackage
`default_nettype wire

// File: rtl/compmag.sv
`default_nettype none
// ============================================================
// Module  : compmag
// Brief   : 4-bit unsigned magnitude comparator
// Revision: 1.0
// ============================================================
module compmag (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       agtb,
  output logic       altb,
  output logic       aeqb
);

  assign agtb = (a > b);
  assign altb = (a < b);
  assign aeqb = (a == b);

endmodule
`default_nettype wire

// File: rtl/level_monitor.sv
`default_nettype none
// ============================================================
// Module  : level_monitor
// Brief   : hysteresis + debounce level detector with event
//           count and peak hold
// Revision: 1.0
// ============================================================
module level_monitor
  import lm_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF,
  parameter int EVW      = EVW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic [3:0]     sample,
  input  logic           sample_valid,
  input  logic [3:0]     hi_th,
  input  logic [3:0]     lo_th,
  output logic           above,
  output logic           rise,
  output logic           fall,
  output logic [EVW-1:0] event_cnt,
  output logic [3:0]     peak,
  output logic           cfg_err
);

  localparam logic [3:0] c_deb = 4'(DEBOUNCE);

  logic w_gt_hi, w_hi_lt, w_hi_eq;
  logic w_lo_gt, w_lt_lo, w_lo_eq;
  logic w_gt_pk, w_pk_lt, w_pk_eq;
  logic w_unused_cmp;

  lm_state_e  r_state, w_state_nxt;
  logic [3:0] r_deb_cnt, w_deb_nxt, w_deb_inc;
  logic       w_rise_nxt, w_fall_nxt, w_above_nxt;

  logic           r_above, r_rise, r_fall, r_cfg_err;
  logic [EVW-1:0] r_event_cnt;
  logic [3:0]     r_peak;

  compmag u_cmp_hi (
    .a    (sample),
    .b    (hi_th),
    .agtb (w_gt_hi),
    .altb (w_hi_lt),
    .aeqb (w_hi_eq)
  );

  compmag u_cmp_lo (
    .a    (sample),
    .b    (lo_th),
    .agtb (w_lo_gt),
    .altb (w_lt_lo),
    .aeqb (w_lo_eq)
  );

  compmag u_cmp_pk (
    .a    (sample),
    .b    (r_peak),
    .agtb (w_gt_pk),
    .altb (w_pk_lt),
    .aeqb (w_pk_eq)
  );

  assign w_unused_cmp = ^{w_hi_lt, w_hi_eq, w_lo_gt, w_lo_eq, w_pk_lt, w_pk_eq};

  assign w_deb_inc = r_deb_cnt + 4'd1;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= LOW;
      r_deb_cnt <= '0;
    end else if (clr) begin
      r_state   <= LOW;
      r_deb_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_deb_cnt <= w_deb_nxt;
    end
  end

  // Next-state logic; a bad threshold pair freezes the level and drops progress
  always_comb begin
    w_state_nxt = r_state;
    w_deb_nxt   = r_deb_cnt;
    if (r_cfg_err) begin
      w_deb_nxt = '0;
    end else if (sample_valid) begin
      case (r_state)
        LOW: begin
          if (w_gt_hi) begin
            if (c_deb == 4'd1) begin
              w_state_nxt = HIGH;
              w_deb_nxt   = '0;
            end else begin
              w_state_nxt = PEND_HI;
              w_deb_nxt   = 4'd1;
            end
          end else begin
            w_deb_nxt = '0;
          end
        end
        PEND_HI: begin
          if (w_gt_hi) begin
            if (w_deb_inc == c_deb) begin
              w_state_nxt = HIGH;
              w_deb_nxt   = '0;
            end else begin
              w_deb_nxt = w_deb_inc;
            end
          end else begin
            w_state_nxt = LOW;
            w_deb_nxt   = '0;
          end
        end
        HIGH: begin
          if (w_lt_lo) begin
            if (c_deb == 4'd1) begin
              w_state_nxt = LOW;
              w_deb_nxt   = '0;
            end else begin
              w_state_nxt = PEND_LO;
              w_deb_nxt   = 4'd1;
            end
          end else begin
            w_deb_nxt = '0;
          end
        end
        PEND_LO: begin
          if (w_lt_lo) begin
            if (w_deb_inc == c_deb) begin
              w_state_nxt = LOW;
              w_deb_nxt   = '0;
            end else begin
              w_deb_nxt = w_deb_inc;
            end
          end else begin
            w_state_nxt = HIGH;
            w_deb_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = LOW;
          w_deb_nxt   = '0;
        end
      endcase
    end
  end

  // Output decode: pulses only on a real level change, not on pending cancels
  always_comb begin
    w_above_nxt = (w_state_nxt == HIGH) || (w_state_nxt == PEND_LO);
    w_rise_nxt  = ((r_state == LOW) || (r_state == PEND_HI)) && (w_state_nxt == HIGH);
    w_fall_nxt  = ((r_state == HIGH) || (r_state == PEND_LO)) && (w_state_nxt == LOW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_above     <= 1'b0;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
      r_event_cnt <= '0;
      r_peak      <= '0;
      r_cfg_err   <= 1'b0;
    end else if (clr) begin
      r_above     <= 1'b0;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
      r_event_cnt <= '0;
      r_peak      <= '0;
      r_cfg_err   <= (lo_th > hi_th);
    end else begin
      r_above   <= w_above_nxt;
      r_rise    <= w_rise_nxt;
      r_fall    <= w_fall_nxt;
      r_cfg_err <= (lo_th > hi_th);
      if (w_rise_nxt && !(&r_event_cnt))
        r_event_cnt <= r_event_cnt + EVW'(1);
      if (sample_valid && w_gt_pk)
        r_peak <= sample;
    end
  end

  assign above     = r_above;
  assign rise      = r_rise;
  assign fall      = r_fall;
  assign event_cnt = r_event_cnt;
  assign peak      = r_peak;
  assign cfg_err   = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_level_monitor.sv
`default_nettype none
// ============================================================
// Module  : tb_level_monitor
// Brief   : directed stimulus with a level/streak reference model
// Revision: 1.0
// ============================================================
module tb_level_monitor;

  localparam int DEB  = 3;
  localparam int EVW  = 8;
  localparam int CMAX = (1 << EVW) - 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           clr;
  logic [3:0]     sample;
  logic           sample_valid;
  logic [3:0]     hi_th;
  logic [3:0]     lo_th;
  logic           above, rise, fall, cfg_err;
  logic [EVW-1:0] event_cnt;
  logic [3:0]     peak;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model: current level plus a run length of qualifying samples
  int m_level, m_streak, m_cnt, m_peak, m_rise, m_fall, m_cfg;

  level_monitor #(.DEBOUNCE(DEB), .EVW(EVW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .sample       (sample),
    .sample_valid (sample_valid),
    .hi_th        (hi_th),
    .lo_th        (lo_th),
    .above        (above),
    .rise         (rise),
    .fall         (fall),
    .event_cnt    (event_cnt),
    .peak         (peak),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_level = 0; m_streak = 0; m_cnt = 0; m_peak = 0;
    m_rise = 0; m_fall = 0; m_cfg = 0;
  endtask

  task automatic model_update();
    int qual;
    if (clr) begin
      m_level = 0; m_streak = 0; m_cnt = 0; m_peak = 0;
      m_rise = 0; m_fall = 0;
    end else begin
      m_rise = 0;
      m_fall = 0;
      if (m_cfg != 0) begin
        m_streak = 0;
      end else if (sample_valid) begin
        qual = (m_level != 0) ? int'(sample < lo_th) : int'(sample > hi_th);
        if (qual != 0) begin
          m_streak++;
          if (m_streak == DEB) begin
            m_streak = 0;
            if (m_level != 0) m_fall = 1;
            else begin
              m_rise = 1;
              if (m_cnt < CMAX) m_cnt++;
            end
            m_level = 1 - m_level;
          end
        end else begin
          m_streak = 0;
        end
      end
      if (sample_valid && int'(sample) > m_peak) m_peak = int'(sample);
    end
    m_cfg = int'(lo_th > hi_th);
  endtask

  // One clock: inputs applied at negedge, model advanced at posedge, return at negedge
  task automatic step(input logic v, input logic [3:0] s, input logic c = 1'b0);
    sample_valid = v;
    sample       = s;
    clr          = c;
    @(posedge clk);
    model_update();
    @(negedge clk);
    sample_valid = 1'b0;
    clr          = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("above",     int'(above),     m_level);
      check("rise",      int'(rise),      m_rise);
      check("fall",      int'(fall),      m_fall);
      check("event_cnt", int'(event_cnt), m_cnt);
      check("peak",      int'(peak),      m_peak);
      check("cfg_err",   int'(cfg_err),   m_cfg);
      if (rise && fall) check("rise_and_fall", 1, 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; sample = 4'd0; sample_valid = 1'b0;
    hi_th = 4'd10; lo_th = 4'd4;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_above", int'(above), 0);
    check("rst_rise",  int'(rise), 0);
    check("rst_fall",  int'(fall), 0);
    check("rst_cnt",   int'(event_cnt), 0);
    check("rst_peak",  int'(peak), 0);
    check("rst_cfg",   int'(cfg_err), 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Basic rise after three qualifying samples
    step(1, 4'd11);
    step(1, 4'd12);
    check("pend_no_rise", int'(rise), 0);
    step(1, 4'd13);
    check("t1_above", int'(above), 1);
    check("t1_rise",  int'(rise), 1);
    check("t1_cnt",   int'(event_cnt), 1);
    check("t1_peak",  int'(peak), 13);
    step(0, 4'd0);
    check("t1_rise_pulse", int'(rise), 0);

    // Fall with a cancelling in-band sample
    step(1, 4'd3);
    step(1, 4'd3);
    step(1, 4'd5);
    check("t2_cancel_above", int'(above), 1);
    step(1, 4'd3);
    step(1, 4'd3);
    check("t2_no_fall_yet", int'(fall), 0);
    step(1, 4'd3);
    check("t2_fall",  int'(fall), 1);
    check("t2_above", int'(above), 0);

    // Invalid gap holds the debounce count; invalid 15 must not touch peak
    step(1, 4'd11);
    repeat (5) step(0, 4'd15);
    check("t3_gap_peak", int'(peak), 13);
    step(1, 4'd12);
    check("t3_no_rise", int'(rise), 0);
    step(1, 4'd13);
    check("t3_rise", int'(rise), 1);
    repeat (3) step(1, 4'd3);
    check("t3_back_low", int'(above), 0);

    // Sample equal to hi_th resets the pending run
    step(1, 4'd11);
    step(1, 4'd12);
    step(1, 4'd10);
    step(1, 4'd11);
    step(1, 4'd12);
    check("t4_eq_no_rise", int'(rise), 0);
    step(1, 4'd13);
    check("t4_rise", int'(rise), 1);
    check("t4_cnt",  int'(event_cnt), 3);
    repeat (3) step(1, 4'd3);

    // Inverted thresholds freeze the level but not peak
    hi_th = 4'd2; lo_th = 4'd9;
    step(0, 4'd0);
    check("t5_cfg_err", int'(cfg_err), 1);
    repeat (4) begin
      step(1, 4'd15);
      check("t5_no_rise", int'(rise), 0);
    end
    check("t5_peak",  int'(peak), 15);
    check("t5_above", int'(above), 0);
    hi_th = 4'd10; lo_th = 4'd4;
    step(0, 4'd0);
    check("t5_cfg_clear", int'(cfg_err), 0);

    // Event counter saturation
    for (int i = 0; i < 256; i++) begin
      repeat (3) step(1, 4'd11);
      repeat (3) step(1, 4'd3);
    end
    check("t6_sat", int'(event_cnt), 255);
    repeat (3) step(1, 4'd11);
    check("t6_sat_hold", int'(event_cnt), 255);
    check("t6_high", int'(above), 1);

    // Clear overrides a simultaneous valid sample
    step(1, 4'd15, 1'b1);
    check("t7_cnt",   int'(event_cnt), 0);
    check("t7_peak",  int'(peak), 0);
    check("t7_above", int'(above), 0);

    // Asynchronous reset mid-debounce
    step(1, 4'd11);
    step(1, 4'd12);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("t8_above", int'(above), 0);
    check("t8_rise",  int'(rise), 0);
    check("t8_cnt",   int'(event_cnt), 0);
    check("t8_peak",  int'(peak), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 4'd13);
    check("t8_no_rise", int'(rise), 0);
    check("t8_low", int'(above), 0);
    step(1, 4'd13);
    step(1, 4'd13);
    check("t8_rise_after", int'(rise), 1);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/level_monitor.md
Name: level_monitor

Overview:
- Sequential consumer of 4-bit magnitude comparisons.
- Watches a stream of 4-bit samples against programmable high/low thresholds and applies hysteresis plus debounce.
- Reports a clean "above" level, rise/fall event pulses, a saturating event count and the peak sample seen.
- Sits directly downstream of the team's 4-bit magnitude comparator (compmag); its agtb/altb/aeqb results drive the FSM.

Parameters:
DEBOUNCE, 3, consecutive qualifying valid samples required to change level; legal range 1..15
EVW, 8, width of event counter

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear of state, counters and peak
sample  input  4  unsigned sample
sample_valid  input  1  sample qualifier; no action when low
hi_th  input  4  rise threshold (sample > hi_th qualifies)
lo_th  input  4  fall threshold (sample < lo_th qualifies)
above  output  1  debounced level
rise  output  1  one-cycle pulse on LOW->HIGH transition
fall  output  1  one-cycle pulse on HIGH->LOW transition
event_cnt  output  EVW  count of rise events, saturating at all-ones
peak  output  4  largest valid sample since reset/clr
cfg_err  output  1  registered: hi_th < lo_th

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low. Reset values: above=0, rise=0, fall=0, event_cnt=0, peak=0, cfg_err=0, state=LOW, deb_cnt=0.
- All outputs are registered. Latency is 1 cycle from the qualifying sample edge to the output update.
- Comparisons: gt_hi = sample > hi_th; lt_lo = sample < lo_th; gt_pk = sample > peak. All unsigned 4-bit.
- cfg_err is updated every cycle from (lo_th > hi_th). While cfg_err=1 the FSM is held in its current state and deb_cnt is cleared. peak tracking continues.
- FSM states LOW, PEND_HI, HIGH, PEND_LO. above=1 in HIGH and PEND_LO.
  - LOW: valid & gt_hi -> deb_cnt=1. If DEBOUNCE==1: go to HIGH with rise. Else go to PEND_HI.
  - PEND_HI: valid & gt_hi -> deb_cnt+1. When deb_cnt+1==DEBOUNCE: go to HIGH, rise=1, deb_cnt=0. Valid & !gt_hi -> LOW, deb_cnt=0.
  - HIGH: valid & lt_lo -> deb_cnt=1. If DEBOUNCE==1: go to LOW with fall. Else go to PEND_LO.
  - PEND_LO: valid & lt_lo -> deb_cnt+1. When deb_cnt+1==DEBOUNCE: go to LOW, fall=1. Valid & !lt_lo -> HIGH, deb_cnt=0.
  - sample_valid=0: state and deb_cnt hold; rise/fall=0.
- rise and fall are never both high. Each is high for exactly one cycle per transition.
- event_cnt increments on each rise. It holds at 2^EVW-1; it does not wrap.
- peak <= sample when valid & gt_pk. Equal samples leave peak unchanged.
- clr (synchronous) returns every register to its reset value next edge, with cfg_err re-evaluated normally. clr overrides a simultaneous valid sample; that sample is discarded, including for peak.
- rst_n asserted mid-debounce aborts immediately. No pulse is emitted.
- Samples between lo_th and hi_th inclusive never qualify. They cancel any pending debounce.

Decomposition:
- Shared package lm_pkg: state enum (LOW, PEND_HI, HIGH, PEND_LO), default constants DEBOUNCE_DEF=3 and EVW_DEF=8.
- Sub-modules: two instances of the 4-bit magnitude comparator compmag.
  - One instance computes sample vs hi_th.
  - The second instance computes sample vs lo_th.
  - The peak comparison uses a third instance, or inline logic.
- FSM, counters and peak register live in level_monitor.

Test Plan:
- Reset, then hi_th=10, lo_th=4, DEBOUNCE=3; valid samples 11,12,13 on consecutive cycles -> above=1 and rise=1 one cycle after the 13; event_cnt=1; peak=13.
- From HIGH: samples 3,3,5,3,3,3 -> the 5 cancels the pending fall; fall=1 only after the final third 3; above=0.
- Samples 11,12 with sample_valid=0 for 5 cycles between them, then 13 -> the gap holds deb_cnt; rise occurs after 13. Sample 10 (equal to hi_th) -> treated as non-qualifying and resets the pending count.
- hi_th=2, lo_th=9 -> cfg_err=1 next cycle; samples of 15 produce no rise; peak still becomes 15. Restoring hi_th=10 -> cfg_err=0.
- 256 rise/fall cycles with EVW=8 -> event_cnt saturates at 255. clr asserted together with sample 15 -> event_cnt=0, peak=0, above=0 next cycle.
- rst_n pulsed low asynchronously mid-PEND_HI (between clock edges) -> all outputs 0 immediately, with no rise afterwards.
